ro_glitch_sched: RTL and testbench
==================================

# ro_glitch_sched

Programmable fault-injection pulse scheduler that drives the ring-oscillator grid enable and mask during an AES encryption. It sits between the UART command/encryption state machine and the RO grid. The command machine loads delay, period, active-cycle, pulse-count and mask values, pulses `start` when the AES core is released, and pulses `stop` on `aes_done`. The block produces a cycle-exact, registered grid enable waveform and reports completion.

## Interface
Parameters:
- `WDT_CYCLES`, default 600000: maximum consecutive cycles `grid_ena` may stay high (10 ms at 60 MHz). Used only when the watchdog is compiled in.

Ports:
- `clkin`  in  1  design clock (60 MHz PLL clock); single clock domain.
- `rstin`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; latches config and begins a schedule.
- `stop`  in  1  one-cycle pulse; aborts the schedule (AES finished).
- `cfg_delay`  in  32  cycles from `start` to the first pulse.
- `cfg_period`  in  32  pulse period in cycles (P).
- `cfg_active`  in  32  high cycles per period (A).
- `cfg_npulses`  in  16  pulse limit (N); 0 means unlimited until `stop`.
- `cfg_mask`  in  8  grid column mask.
- `grid_ena`  out  1  registered RO grid enable.
- `grid_mask`  out  8  latched mask applied to the grid.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE exits.
- `done`  out  1  one-cycle completion pulse.
- `pulse_cnt`  out  16  number of pulses started in the current or last schedule.
- `wdt_trip`  out  1  sticky watchdog abort flag.

## Operation
- States: IDLE, DELAY, RUN, DONE.
- IDLE:
  - `start` latches all `cfg_*` inputs.
  - It clears `pulse_cnt` and `wdt_trip`.
  - Next state is DELAY if D>0, otherwise RUN.
  - `stop` is ignored in IDLE. If `start` and `stop` arrive in the same IDLE cycle, `start` is accepted.
- DELAY: a 32-bit down-counter starts at D. On reaching 1, the next state is RUN.
- RUN:
  - A phase counter runs 0..P-1 and wraps to 0.
  - `grid_ena` is high while phase < A.
  - `pulse_cnt` increments (saturating at 16'hFFFF) when phase==0 and A>0.
  - When N≠0 and the Nth period completes (phase==P-1 with `pulse_cnt`==N), the next state is DONE.
- Edge cases:
  - P==0 is treated as P==1.
  - A==0: `grid_ena` never rises and `pulse_cnt` stays 0. The schedule ends only via `stop`, or via the N-limit counted on periods.
  - A≥P: `grid_ena` is continuously high in RUN.
- `stop` in DELAY or RUN: next state is DONE, and `grid_ena` goes low on the next cycle.
- DONE: `done`=1 for one cycle, `grid_ena`=0, next state IDLE.
- `start` while `busy` is ignored.
- `grid_mask` takes the latched `cfg_mask` on an accepted `start` and holds it until the next accepted `start`.
- Config inputs may change freely while `busy`; only the latched copies are used.

## Timing
- All outputs are registered.
- Reset values:
  - `grid_ena`=0, `grid_mask`=8'hFF, `busy`=0, `done`=0, `pulse_cnt`=0, `wdt_trip`=0.
  - State is IDLE and all counters are 0.
- Reset mid-schedule: on the cycle after `rstin` is high, all outputs take their reset values. No `done` pulse is produced.
- `start` sampled high at edge t:
  - `busy` is high from t+1.
  - First `grid_ena` high is at t+1+D and lasts A cycles.
  - It rises again every P cycles.
- `stop` sampled at edge s: `grid_ena`=0 and `done`=1 at s+1; `busy`=0 at s+2.
- N-limit completion: `done` is asserted the cycle after the last phase P-1.

## Configuration
- Macro: `RO_GLITCH_WDT_EN`.
- Defined:
  - A counter tracks consecutive cycles with `grid_ena` high, cleared whenever `grid_ena` is low.
  - When it reaches `WDT_CYCLES`, the next cycle forces `grid_ena`=0, sets `wdt_trip`=1 and enters DONE.
  - `wdt_trip` stays set until the next accepted `start` or reset.
- Not defined: no watchdog counter, `wdt_trip` is tied to 0, and `WDT_CYCLES` is unused.

## Test plan
- Basic schedule: D=3, P=10, A=4, N=2, mask=8'h0F, `start` at t. Required: `grid_ena` high during t+4..t+7 and t+14..t+17; `done` at t+24; `pulse_cnt`=2; `grid_mask`=8'h0F.
- Zero delay, unlimited pulses: D=0, P=5, A=2, N=0. Required: `grid_ena` high at t+1. With `stop` at t+13, `grid_ena`=0 and `done`=1 at t+14, and `pulse_cnt`=3.
- Edge values: A=0 with N=0 gives no `grid_ena` and `done` only after `stop`. A=20 with P=8 gives `grid_ena` continuously high until `stop`.
- Handshake races:
  - `start`+`stop` in the same IDLE cycle → schedule starts.
  - A second `start` while busy → ignored, latched config unchanged.
  - Reset asserted mid-RUN → all outputs at reset values next cycle, with no `done`.
- Watchdog (`RO_GLITCH_WDT_EN`, `WDT_CYCLES`=16): P=100, A=50. Required: `grid_ena` drops after 16 high cycles, `wdt_trip`=1 and `done` pulses. Without the macro, the same stimulus gives 50 high cycles and `wdt_trip`=0.

Source files
------------

// File: rtl/ro_glitch_sched.sv
// ro_glitch_sched: programmable fault-injection pulse scheduler for the
// ring-oscillator grid. Latches a delay/period/active/count/mask schedule on
// `start`, then produces a registered, cycle-exact grid enable waveform until
// the pulse limit is reached or `stop` aborts it.
// Optional watchdog: define RO_GLITCH_WDT_EN to cap consecutive grid_ena-high
// cycles at WDT_CYCLES (sticky wdt_trip, schedule forced to DONE).
module ro_glitch_sched #(
  parameter int unsigned WDT_CYCLES = 600000
) (
  input  logic        clkin,
  input  logic        rstin,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_delay,
  input  logic [31:0] cfg_period,
  input  logic [31:0] cfg_active,
  input  logic [15:0] cfg_npulses,
  input  logic [7:0]  cfg_mask,
  output logic        grid_ena,
  output logic [7:0]  grid_mask,
  output logic        busy,
  output logic        done,
  output logic [15:0] pulse_cnt,
  output logic        wdt_trip
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] dly_cnt_q, dly_cnt_n;
  logic [31:0] phase_q, phase_n;
  logic [15:0] per_cnt_q, per_cnt_n;
  logic [31:0] period_q, active_q;
  logic [15:0] npulses_q;

  logic        grid_ena_n, busy_n, done_n, wdt_trip_n;
  logic [7:0]  grid_mask_n;
  logic [15:0] pulse_cnt_n;

  logic        accept;
  logic [31:0] period_m1;
  logic        last_phase;
  logic        n_limit;
  logic [31:0] act_sel;
  logic        wdt_fire;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept     = (state_q == S_IDLE) && start;
  // A period of 0 behaves as a period of 1, so the last phase is still 0.
  assign period_m1  = (period_q == '0) ? '0 : period_q - 32'd1;
  assign last_phase = (phase_q == period_m1);
  // Periods are counted separately from pulses so the limit also works with A==0.
  assign n_limit    = (npulses_q != '0) && last_phase && (per_cnt_q == npulses_q);
  // On the accepting cycle the latched copy is not yet loaded.
  assign act_sel    = accept ? cfg_active : active_q;

`ifdef RO_GLITCH_WDT_EN
  localparam logic [31:0] WDT_LAST = WDT_CYCLES - 32'd1;
  logic [31:0] wdt_cnt_q;

  assign wdt_fire = grid_ena && (wdt_cnt_q == WDT_LAST);

  // Count consecutive cycles with the grid enabled; any low cycle clears it.
  always_ff @(posedge clkin) begin
    if (rstin) begin
      wdt_cnt_q <= '0;
    end else if (grid_ena) begin
      wdt_cnt_q <= wdt_cnt_q + 32'd1;
    end else begin
      wdt_cnt_q <= '0;
    end
  end
`else
  logic unused_wdt_cycles;
  assign unused_wdt_cycles = ^WDT_CYCLES;
  assign wdt_fire          = 1'b0;
`endif

  // State register, schedule counters, latched config and registered outputs.
  always_ff @(posedge clkin) begin
    if (rstin) begin
      state_q   <= S_IDLE;
      dly_cnt_q <= '0;
      phase_q   <= '0;
      per_cnt_q <= '0;
      period_q  <= '0;
      active_q  <= '0;
      npulses_q <= '0;
      grid_ena  <= 1'b0;
      grid_mask <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      wdt_trip  <= 1'b0;
    end else begin
      state_q   <= state_n;
      dly_cnt_q <= dly_cnt_n;
      phase_q   <= phase_n;
      per_cnt_q <= per_cnt_n;
      if (accept) begin
        period_q  <= cfg_period;
        active_q  <= cfg_active;
        npulses_q <= cfg_npulses;
      end
      grid_ena  <= grid_ena_n;
      grid_mask <= grid_mask_n;
      busy      <= busy_n;
      done      <= done_n;
      pulse_cnt <= pulse_cnt_n;
      wdt_trip  <= wdt_trip_n;
    end
  end

  // Next state plus the delay, phase and period counters.
  always_comb begin
    state_n   = state_q;
    dly_cnt_n = dly_cnt_q;
    phase_n   = phase_q;
    per_cnt_n = per_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          per_cnt_n = '0;
          phase_n   = '0;
          if (cfg_delay != '0) begin
            state_n   = S_DELAY;
            dly_cnt_n = cfg_delay;
          end else begin
            state_n = S_RUN;
          end
        end
      end
      S_DELAY: begin
        if (stop) begin
          state_n = S_DONE;
        end else if (dly_cnt_q == 32'd1) begin
          state_n = S_RUN;
          phase_n = '0;
        end else begin
          dly_cnt_n = dly_cnt_q - 32'd1;
        end
      end
      S_RUN: begin
        if (stop || n_limit) begin
          state_n = S_DONE;
        end else if (last_phase) begin
          phase_n = '0;
        end else begin
          phase_n = phase_q + 32'd1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (wdt_fire) begin
      state_n = S_DONE;
    end
    if ((state_n == S_RUN) && (phase_n == '0)) begin
      per_cnt_n = sat_inc(per_cnt_n);
    end
  end

  // Output values for the next cycle, derived from the upcoming state and phase.
  always_comb begin
    grid_ena_n  = (state_n == S_RUN) && (phase_n < act_sel);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
    grid_mask_n = accept ? cfg_mask : grid_mask;
    pulse_cnt_n = accept ? '0 : pulse_cnt;
    if ((state_n == S_RUN) && (phase_n == '0) && (act_sel != '0)) begin
      pulse_cnt_n = sat_inc(pulse_cnt_n);
    end
    wdt_trip_n = accept ? 1'b0 : wdt_trip;
    if (wdt_fire) begin
      wdt_trip_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_ro_glitch_sched.sv
// Self-checking bench for ro_glitch_sched: directed vector table, hand-written
// handshake/reset sequences and randomized schedules against an arithmetic
// reference model of the pulse timeline.
module tb_ro_glitch_sched;

  localparam int WDT = 16;
  localparam int INF = 1000000;

  logic        clkin = 1'b0;
  logic        rstin, start, stop;
  logic [31:0] cfg_delay, cfg_period, cfg_active;
  logic [15:0] cfg_npulses;
  logic [7:0]  cfg_mask;
  logic        grid_ena, busy, done, wdt_trip;
  logic [7:0]  grid_mask;
  logic [15:0] pulse_cnt;

  always #5 clkin = ~clkin;

  ro_glitch_sched #(.WDT_CYCLES(WDT)) dut (
    .clkin(clkin), .rstin(rstin), .start(start), .stop(stop),
    .cfg_delay(cfg_delay), .cfg_period(cfg_period), .cfg_active(cfg_active),
    .cfg_npulses(cfg_npulses), .cfg_mask(cfg_mask),
    .grid_ena(grid_ena), .grid_mask(grid_mask), .busy(busy), .done(done),
    .pulse_cnt(pulse_cnt), .wdt_trip(wdt_trip)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Captured outputs of one schedule, indexed by cycles after the start edge.
  logic        cap_ena  [0:127];
  logic        cap_busy [0:127];
  logic        cap_done [0:127];
  logic        cap_wdt  [0:127];
  logic [7:0]  cap_mask [0:127];
  logic [15:0] cap_pcnt [0:127];

  task automatic run_sched(input int d, input int p, input int a, input int n,
                           input logic [7:0] m, input int stop_k, input int len);
    @(negedge clkin);
    cfg_delay   = 32'(d);
    cfg_period  = 32'(p);
    cfg_active  = 32'(a);
    cfg_npulses = 16'(n);
    cfg_mask    = m;
    start       = 1'b1;
    stop        = (stop_k == 0);
    for (int k = 1; k <= len; k++) begin
      @(negedge clkin);
      start       = 1'b0;
      stop        = (k == stop_k);
      cap_ena[k]  = grid_ena;
      cap_busy[k] = busy;
      cap_done[k] = done;
      cap_wdt[k]  = wdt_trip;
      cap_mask[k] = grid_mask;
      cap_pcnt[k] = pulse_cnt;
    end
  endtask

  task automatic go_idle(input string name);
    @(negedge clkin);
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clkin);
    stop = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy && !done) break;
      @(negedge clkin);
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int          d, p, a, n;
    logic [7:0]  m;
    int          stop_k, k;
    logic        ena, busy, done;
    logic [15:0] pcnt;
    logic        wdt;
  } vec_t;

  vec_t vt [0:39];
  int   nv = 0;

  task automatic add_vec(input int d, input int p, input int a, input int n,
                         input logic [7:0] m, input int stop_k, input int k,
                         input logic ena, input logic bsy, input logic dn,
                         input logic [15:0] pcnt, input logic wdt);
    vt[nv].d = d; vt[nv].p = p; vt[nv].a = a; vt[nv].n = n; vt[nv].m = m;
    vt[nv].stop_k = stop_k; vt[nv].k = k;
    vt[nv].ena = ena; vt[nv].busy = bsy; vt[nv].done = dn;
    vt[nv].pcnt = pcnt; vt[nv].wdt = wdt;
    nv++;
  endtask

  // Reference model state for the randomized schedules.
  int rd, rp, ra, rn, rpe, rr, rstop, rend, wcand, k2;
  logic [7:0] rm;
  logic rwdt;

  function automatic int pc_at(input int kk);
    int v;
    if (ra > 0 && kk >= rr) begin
      v = (kk - rr) / rpe + 1;
      return (v > 65535) ? 65535 : v;
    end
    return 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rstin = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_delay = '0; cfg_period = '0; cfg_active = '0; cfg_npulses = '0; cfg_mask = '0;
    repeat (3) @(negedge clkin);
    chk("rst_ena",  32'(grid_ena),  32'd0);
    chk("rst_mask", 32'(grid_mask), 32'hFF);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_done", 32'(done),      32'd0);
    chk("rst_pcnt", 32'(pulse_cnt), 32'd0);
    chk("rst_wdt",  32'(wdt_trip),  32'd0);
    rstin = 1'b0;
    @(negedge clkin);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Basic schedule: D=3 P=10 A=4 N=2
    add_vec(3, 10, 4, 2, 8'h0F, -1,  3, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1,  4, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1,  7, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1,  8, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1, 14, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1, 17, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1, 18, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1, 23, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1, 24, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
    add_vec(3, 10, 4, 2, 8'h0F, -1, 25, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0);
    // Zero delay, unlimited, stop at 13
    add_vec(0, 5, 2, 0, 8'hA5, 13,  1, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(0, 5, 2, 0, 8'hA5, 13,  3, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(0, 5, 2, 0, 8'hA5, 13,  6, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0);
    add_vec(0, 5, 2, 0, 8'hA5, 13, 13, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
    add_vec(0, 5, 2, 0, 8'hA5, 13, 14, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
    add_vec(0, 5, 2, 0, 8'hA5, 13, 15, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0);
    // A=0, unlimited: only stop ends it
    add_vec(1, 6, 0, 0, 8'h33, 20, 10, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    add_vec(1, 6, 0, 0, 8'h33, 20, 21, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
    add_vec(1, 6, 0, 0, 8'h33, 20, 22, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    // A>=P: continuously high
    add_vec(2, 8, 20, 0, 8'h77, 12,  3, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(2, 8, 20, 0, 8'h77, 12, 11, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0);
    add_vec(2, 8, 20, 0, 8'h77, 12, 12, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0);
    add_vec(2, 8, 20, 0, 8'h77, 12, 13, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
    // A=0 with N-limit counted on periods
    add_vec(0, 4, 0, 3, 8'h11, -1, 12, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    add_vec(0, 4, 0, 3, 8'h11, -1, 13, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
    // P=0 behaves as P=1
    add_vec(0, 0, 1, 3, 8'h22, -1,  1, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(0, 0, 1, 3, 8'h22, -1,  3, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0);
    add_vec(0, 0, 1, 3, 8'h22, -1,  4, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
    // start and stop in the same IDLE cycle: start wins
    add_vec(2, 4, 2, 1, 8'h44,  0,  1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    add_vec(2, 4, 2, 1, 8'h44,  0,  3, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(2, 4, 2, 1, 8'h44,  0,  7, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    // Watchdog: P=100 A=50
`ifdef RO_GLITCH_WDT_EN
    add_vec(0, 100, 50, 0, 8'h5A, 70, 16, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(0, 100, 50, 0, 8'h5A, 70, 17, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1);
    add_vec(0, 100, 50, 0, 8'h5A, 70, 18, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
`else
    add_vec(0, 100, 50, 0, 8'h5A, 70, 16, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(0, 100, 50, 0, 8'h5A, 70, 50, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(0, 100, 50, 0, 8'h5A, 70, 51, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);
    add_vec(0, 100, 50, 0, 8'h5A, 70, 71, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
`endif

    for (int i = 0; i < nv; i++) begin
      int k;
      k = vt[i].k;
      run_sched(vt[i].d, vt[i].p, vt[i].a, vt[i].n, vt[i].m, vt[i].stop_k, k);
      chk($sformatf("vec%0d_k%0d_ena", i, k),  32'(cap_ena[k]),  32'(vt[i].ena));
      chk($sformatf("vec%0d_k%0d_busy", i, k), 32'(cap_busy[k]), 32'(vt[i].busy));
      chk($sformatf("vec%0d_k%0d_done", i, k), 32'(cap_done[k]), 32'(vt[i].done));
      chk($sformatf("vec%0d_k%0d_pcnt", i, k), 32'(cap_pcnt[k]), 32'(vt[i].pcnt));
      chk($sformatf("vec%0d_k%0d_mask", i, k), 32'(cap_mask[k]), 32'(vt[i].m));
      chk($sformatf("vec%0d_k%0d_wdt", i, k),  32'(cap_wdt[k]),  32'(vt[i].wdt));
      go_idle($sformatf("vec%0d", i));
    end

    // Second start while busy is ignored; latched config stays in force.
    @(negedge clkin);
    cfg_delay = 32'd0; cfg_period = 32'd6; cfg_active = 32'd3;
    cfg_npulses = 16'd2; cfg_mask = 8'h3C; start = 1'b1; stop = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clkin);
      chk($sformatf("restart_k%0d_ena", k), 32'(grid_ena),
          32'((k < 13) && (((k - 1) % 6) < 3)));
      chk($sformatf("restart_k%0d_done", k), 32'(done), 32'(k == 13));
      start = (k == 2);
      if (k == 2) begin
        cfg_period = 32'd2; cfg_active = 32'd1; cfg_npulses = 16'd5; cfg_mask = 8'hC3;
      end
    end
    chk("restart_mask", 32'(grid_mask), 32'h3C);
    chk("restart_pcnt", 32'(pulse_cnt), 32'd2);
    chk("restart_busy", 32'(busy), 32'd0);

    // Reset asserted mid-RUN: reset values next cycle and no done pulse.
    run_sched(0, 10, 5, 0, 8'h99, -1, 3);
    chk("midrst_pre_ena", 32'(cap_ena[3]), 32'd1);
    rstin = 1'b1;
    @(negedge clkin);
    chk("midrst_ena",  32'(grid_ena),  32'd0);
    chk("midrst_mask", 32'(grid_mask), 32'hFF);
    chk("midrst_busy", 32'(busy),      32'd0);
    chk("midrst_done", 32'(done),      32'd0);
    chk("midrst_pcnt", 32'(pulse_cnt), 32'd0);
    chk("midrst_wdt",  32'(wdt_trip),  32'd0);
    rstin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clkin);
      chk($sformatf("midrst_after%0d_done", k), 32'(done), 32'd0);
      chk($sformatf("midrst_after%0d_ena", k), 32'(grid_ena), 32'd0);
    end

    // Randomized schedules against the timeline model.
    for (int s = 0; s < 60; s++) begin
      rd = int'($urandom_range(0, 6));
      rp = int'($urandom_range(0, 10));
      ra = int'($urandom_range(0, 12));
      rn = int'($urandom_range(0, 4));
      rm = 8'($urandom);
      rpe = (rp == 0) ? 1 : rp;
      rr = 1 + rd;
      if (rn == 0) rstop = int'($urandom_range(1, 45));
      else rstop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 50)) : -1;
      rend = (rn != 0) ? rr + rn * rpe : INF;
      wcand = INF;
`ifdef RO_GLITCH_WDT_EN
      if (ra > 0 && (ra >= rpe || ra >= WDT)) wcand = rr + WDT;
`endif
      if (wcand < rend) rend = wcand;
      if (rstop >= 1 && rstop + 1 < rend) rend = rstop + 1;
      rwdt = (wcand == rend);
      k2 = int'($urandom_range(1, 20));

      @(negedge clkin);
      cfg_delay = 32'(rd); cfg_period = 32'(rp); cfg_active = 32'(ra);
      cfg_npulses = 16'(rn); cfg_mask = rm;
      start = 1'b1;
      stop = (rstop == 0);
      for (int k = 1; k <= rend + 2; k++) begin
        logic e_ena, e_busy, e_done, e_wdt;
        int   e_pc;
        @(negedge clkin);
        if (k < rend) begin
          e_busy = 1'b1; e_done = 1'b0;
          e_ena  = (k >= rr) && (((k - rr) % rpe) < ra);
          e_pc   = pc_at(k);
          e_wdt  = 1'b0;
        end else if (k == rend) begin
          e_busy = 1'b1; e_done = 1'b1; e_ena = 1'b0;
          e_pc   = pc_at(k - 1);
          e_wdt  = rwdt;
        end else begin
          e_busy = 1'b0; e_done = 1'b0; e_ena = 1'b0;
          e_pc   = pc_at(rend - 1);
          e_wdt  = rwdt;
        end
        chk($sformatf("rnd%0d_k%0d_ena", s, k),  32'(grid_ena),  32'(e_ena));
        chk($sformatf("rnd%0d_k%0d_busy", s, k), 32'(busy),      32'(e_busy));
        chk($sformatf("rnd%0d_k%0d_done", s, k), 32'(done),      32'(e_done));
        chk($sformatf("rnd%0d_k%0d_pcnt", s, k), 32'(pulse_cnt), 32'(e_pc));
        chk($sformatf("rnd%0d_k%0d_wdt", s, k),  32'(wdt_trip),  32'(e_wdt));
        chk($sformatf("rnd%0d_k%0d_mask", s, k), 32'(grid_mask), 32'(rm));
        start = (k == k2) && (k <= rend);
        stop  = (k == rstop);
        cfg_delay = $urandom; cfg_period = $urandom; cfg_active = $urandom;
        cfg_npulses = 16'($urandom); cfg_mask = 8'($urandom);
      end
      start = 1'b0;
      stop  = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
